tx_channel_arbiter: RTL and testbench
=====================================

# tx_channel_arbiter

Shares the single byte-wide transmit channel toward the UART clock domain between two requesters in the system domain: the ALU result path (two bytes per transaction) and the register-file read path (one byte). It arbitrates, captures the winning payload, and serializes it byte by byte. Each byte is presented as a level-held enable plus stable data so the destination-side enable synchronizer and pulse generator capture it exactly once. It paces transfers against the synchronized busy flag returned from the UART domain.

## Interface

- WIDTH, 8, byte width of the channel.
- HOLD_CYCLES, 4, cycles o_tx_en stays high per byte; must be ≥2 and must exceed the destination synchronizer depth plus one.
- GAP_CYCLES, 3, cycles o_tx_en stays low after each byte before busy is sampled; must be ≥1 and must cover the busy round-trip latency.
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_alu_valid  input  1  ALU result request, held until o_alu_ready is seen.
- i_alu_data  input  2*WIDTH  ALU result; low byte is sent first.
- o_alu_ready  output  1  one-cycle acceptance pulse to the ALU path.
- i_rf_valid  input  1  register-file read request, held until o_rf_ready is seen.
- i_rf_data  input  WIDTH  register read byte.
- o_rf_ready  output  1  one-cycle acceptance pulse to the RF path.
- o_tx_data  output  WIDTH  byte toward the UART domain, stable whenever o_tx_en is high.
- o_tx_en  output  1  level enable toward the UART domain.
- i_tx_busy  input  1  UART TX busy, already synchronized into i_clk.

## Operation

- State machine: IDLE, SEND, GAP, WAIT.
- IDLE: if (i_alu_valid | i_rf_valid) & ~i_tx_busy, then grant per the arbitration rule.
  - Capture the payload into an internal 2*WIDTH buffer and load bytes_left: 2 for ALU, 1 for RF.
  - Register the ready pulse of the winner.
  - Go to SEND.
- SEND: o_tx_en=1 and o_tx_data=current byte for HOLD_CYCLES cycles. Then decrement bytes_left and go to GAP.
- GAP: o_tx_en=0 for GAP_CYCLES cycles, then go to WAIT.
- WAIT: wait until i_tx_busy=0.
  - If bytes_left≠0, shift the buffer to the high byte and go to SEND.
  - Otherwise go to IDLE.
- o_tx_data is held at its last value outside SEND. It is never changed while o_tx_en=1.
- A single cycle counter serves HOLD and GAP. Its width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
- Requests are ignored outside IDLE. Payloads are never dropped or reordered within a requester.
- Reset (i_rst=1 on a clock edge), at any state including mid-byte:
  - state=IDLE
  - o_tx_en=0
  - o_tx_data=0
  - o_alu_ready=0
  - o_rf_ready=0
  - counter=0
  - bytes_left=0
  - priority pointer=ALU
  - Any partially sent transaction is abandoned; the requester re-presents it.

## Timing

- Acceptance at clock edge T (IDLE):
  - o_*_ready is high during cycle T+1 only.
  - o_tx_en is high from T+1 through T+HOLD_CYCLES.
- The requester drops or updates valid after sampling ready. This is safe because IDLE is not re-entered before T+HOLD_CYCLES+GAP_CYCLES+1.
- Byte period, minimum: HOLD_CYCLES+GAP_CYCLES+1 cycles (including one WAIT cycle), plus time spent with busy high.
- RF transaction, minimum: 1 byte period. ALU transaction, minimum: 2 byte periods.
- IDLE to next grant: earliest on the edge after WAIT exits, so there is one IDLE cycle between transactions.
- i_tx_busy high in IDLE blocks the grant; no ready pulse is issued.

## Configuration

- TX_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer selects which requester wins when both are valid.
  - After each grant the pointer moves to the other requester.
  - The reset pointer favours ALU.
- TX_ARB_RR_EN undefined: fixed priority. ALU always wins over RF when both are valid, and the pointer logic is absent.

## Test plan

- Reset, then i_rf_valid=1 with i_rf_data=8'hA5 and busy=0 → o_rf_ready pulse at T+1; o_tx_en high 4 cycles with o_tx_data=A5, then low; return to IDLE.
- i_alu_valid with i_alu_data=16'h1234, busy=0 → byte 34 held 4 cycles, 3-cycle gap, then byte 12 held 4 cycles; exactly one o_alu_ready pulse.
- Both valid continuously (ALU=16'hBEEF, RF=8'h5A):
  - With TX_ARB_RR_EN: grant order ALU, RF, ALU.
  - Without TX_ARB_RR_EN: ALU is always granted.
- i_tx_busy held high for 10 cycles after the first ALU byte → second byte starts only after busy falls; o_tx_data stays stable; no extra o_tx_en rise.
- i_rst asserted during the second cycle of SEND → next cycle o_tx_en=0, o_tx_data=0, state IDLE; a re-presented request is accepted normally.
- i_tx_busy=1 in IDLE with RF valid → no ready, no o_tx_en for as long as busy holds; grant on the first cycle busy=0.

Source files
------------

// File: rtl/tx_channel_arbiter_if.sv
// Transmit-channel arbiter bundle: two requesters in, one byte channel out.
// master = arbiter side, slave = requesters / UART-domain side.
interface tx_channel_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               i_alu_valid;
  logic [2*WIDTH-1:0] i_alu_data;
  logic               o_alu_ready;
  logic               i_rf_valid;
  logic [WIDTH-1:0]   i_rf_data;
  logic               o_rf_ready;
  logic [WIDTH-1:0]   o_tx_data;
  logic               o_tx_en;
  logic               i_tx_busy;

  modport master (
    input  i_alu_valid, i_alu_data,
    input  i_rf_valid, i_rf_data,
    input  i_tx_busy,
    output o_alu_ready, o_rf_ready,
    output o_tx_data, o_tx_en
  );

  modport slave (
    output i_alu_valid, i_alu_data,
    output i_rf_valid, i_rf_data,
    output i_tx_busy,
    input  o_alu_ready, o_rf_ready,
    input  o_tx_data, o_tx_en
  );
endinterface

// File: rtl/tx_channel_arbiter.sv
// Arbitrates ALU / RF payloads onto a level-held byte channel toward UART.
// Option macro TX_ARB_RR_EN: round-robin; undefined: ALU fixed priority.
module tx_channel_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input logic i_clk,
  input logic i_rst,
  tx_channel_arbiter_if.master bus
);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_GAP, S_WAIT
  } state_t;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [1:0]         r_left, w_left;
  logic [2*WIDTH-1:0] r_buf, w_buf;
  logic [WIDTH-1:0]   r_tx_data, w_tx_data;
  logic               r_tx_en, w_tx_en;
  logic               r_alu_rdy, w_alu_rdy;
  logic               r_rf_rdy, w_rf_rdy;
  logic               w_grant;
  logic               w_pick_alu;

  // A grant needs a request, an idle arbiter and a quiet UART.
  always_comb begin
    w_grant = (r_state == S_IDLE) &
              (bus.i_alu_valid | bus.i_rf_valid) &
              ~bus.i_tx_busy;
  end

`ifdef TX_ARB_RR_EN
  logic r_ptr, w_ptr;

  // Pointer 0 favours ALU; it flips to the loser after every grant.
  always_comb begin
    w_pick_alu = bus.i_alu_valid & (~bus.i_rf_valid | ~r_ptr);
    w_ptr      = r_ptr;
    if (w_grant) w_ptr = w_pick_alu;
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_ptr <= 1'b0;
    else       r_ptr <= w_ptr;
  end
`else
  // ALU wins whenever it is requesting.
  always_comb begin
    w_pick_alu = bus.i_alu_valid;
  end
`endif

  // Next-state and output logic of the transmit sequencer.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_left    = r_left;
    w_buf     = r_buf;
    w_tx_data = r_tx_data;
    w_tx_en   = r_tx_en;
    w_alu_rdy = 1'b0;
    w_rf_rdy  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state = S_SEND;
          w_cnt   = '0;
          w_tx_en = 1'b1;
          if (w_pick_alu) begin
            w_buf     = bus.i_alu_data;
            w_left    = 2'd2;
            w_alu_rdy = 1'b1;
            w_tx_data = bus.i_alu_data[WIDTH-1:0];
          end else begin
            w_buf     = {{WIDTH{1'b0}}, bus.i_rf_data};
            w_left    = 2'd1;
            w_rf_rdy  = 1'b1;
            w_tx_data = bus.i_rf_data;
          end
        end
      end
      S_SEND: begin
        if (r_cnt == HOLD_LAST) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_tx_en = 1'b0;
          w_left  = r_left - 2'd1;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state = S_WAIT;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (~bus.i_tx_busy) begin
          if (r_left != 2'd0) begin
            w_state   = S_SEND;
            w_tx_en   = 1'b1;
            w_tx_data = r_buf[2*WIDTH-1:WIDTH];
            w_buf     = r_buf >> WIDTH;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset abandons any transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_left    <= 2'd0;
      r_buf     <= '0;
      r_tx_data <= '0;
      r_tx_en   <= 1'b0;
      r_alu_rdy <= 1'b0;
      r_rf_rdy  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_left    <= w_left;
      r_buf     <= w_buf;
      r_tx_data <= w_tx_data;
      r_tx_en   <= w_tx_en;
      r_alu_rdy <= w_alu_rdy;
      r_rf_rdy  <= w_rf_rdy;
    end
  end

  assign bus.o_tx_data   = r_tx_data;
  assign bus.o_tx_en     = r_tx_en;
  assign bus.o_alu_ready = r_alu_rdy;
  assign bus.o_rf_ready  = r_rf_rdy;
endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Scoreboard bench for tx_channel_arbiter (directed + random traffic).
// Build with +define+TX_ARB_RR_EN to check round-robin arbitration.
module tb_tx_channel_arbiter;
  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tx_channel_arbiter_if #(.WIDTH(W)) bus ();

  tx_channel_arbiter #(
    .WIDTH(W), .HOLD_CYCLES(H), .GAP_CYCLES(G)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: who wins when both request, given who was served last.
  function automatic bit model_pick_alu(bit av, bit rv, bit last_rf);
`ifdef TX_ARB_RR_EN
    if (av && rv) return last_rf;
`else
    if (av && rv) return 1'b1;
`endif
    return av;
  endfunction

  logic [W-1:0] exp_q[$];
  bit           last_rf  = 1'b1;
  logic         p_en     = 1'b0;
  logic         p_busy   = 1'b0;
  logic         p_av     = 1'b0;
  logic         p_rv     = 1'b0;
  logic         p_rst    = 1'b1;
  logic [W-1:0] cur      = '0;
  int           hold_len = 0;
  int           low_len  = 100;
  bit           busy_low = 1'b0;
  bit           granted;

  // Monitor: grants push expected bytes, channel bytes pop and compare.
  always @(negedge clk) begin
    granted = 1'b0;
    if (p_rst) begin
      chk("rst_tx_en", bus.o_tx_en, 0);
      chk("rst_tx_data", bus.o_tx_data, 0);
      chk("rst_alu_ready", bus.o_alu_ready, 0);
      chk("rst_rf_ready", bus.o_rf_ready, 0);
      exp_q.delete();
      last_rf  = 1'b1;
      cur      = '0;
      hold_len = 0;
      low_len  = 100;
      busy_low = 1'b0;
    end else begin
      if (bus.o_alu_ready || bus.o_rf_ready) begin
        granted = 1'b1;
        chk("grant_onehot", bus.o_alu_ready & bus.o_rf_ready, 0);
        chk("grant_busy", p_busy, 0);
        chk("grant_any_valid", p_av | p_rv, 1);
        chk("grant_winner", bus.o_alu_ready,
            model_pick_alu(p_av, p_rv, last_rf));
        chk("grant_en_rise", {bus.o_tx_en, p_en}, 2'b10);
        if (bus.o_alu_ready) begin
          exp_q.push_back(bus.i_alu_data[W-1:0]);
          exp_q.push_back(bus.i_alu_data[2*W-1:W]);
          last_rf = 1'b0;
        end else begin
          exp_q.push_back(bus.i_rf_data);
          last_rf = 1'b1;
        end
      end
      if (bus.o_tx_en && !p_en) begin
        chk("rise_busy", p_busy, 0);
        if (granted)
          chk("idle_gap_min", low_len >= G + 2, 1);
        else if (!busy_low)
          chk("inner_gap_len", low_len, G + 1);
        else
          chk("inner_gap_min", low_len >= G + 1, 1);
        if (exp_q.size() == 0)
          chk("spurious_byte", bus.o_tx_data, 'hFFFF);
        else
          chk("byte_data", bus.o_tx_data, exp_q.pop_front());
        cur      = bus.o_tx_data;
        hold_len = 1;
      end else if (bus.o_tx_en && p_en) begin
        hold_len++;
        chk("data_stable", bus.o_tx_data, cur);
      end else if (!bus.o_tx_en && p_en) begin
        chk("hold_len", hold_len, H);
        chk("data_held", bus.o_tx_data, cur);
        low_len  = 1;
        busy_low = bus.i_tx_busy;
      end else begin
        chk("data_held", bus.o_tx_data, cur);
        low_len++;
        busy_low = busy_low | bus.i_tx_busy;
      end
    end
    p_en   = bus.o_tx_en;
    p_busy = bus.i_tx_busy;
    p_av   = bus.i_alu_valid;
    p_rv   = bus.i_rf_valid;
    p_rst  = rst;
  end

  task automatic send_alu(input logic [2*W-1:0] d);
    int n = 0;
    bus.i_alu_valid = 1'b1;
    bus.i_alu_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_alu_ready && n < 3000);
    chk("alu_accept", bus.o_alu_ready, 1);
    @(posedge clk);
    #1 bus.i_alu_valid = 1'b0;
  endtask

  task automatic send_rf(input logic [W-1:0] d);
    int n = 0;
    bus.i_rf_valid = 1'b1;
    bus.i_rf_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_rf_ready && n < 3000);
    chk("rf_accept", bus.o_rf_ready, 1);
    @(posedge clk);
    #1 bus.i_rf_valid = 1'b0;
  endtask

  task automatic wait_en(input logic lvl);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_tx_en !== lvl && n < 3000);
    chk("wait_tx_en", bus.o_tx_en, lvl);
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic rand_alu(input int n);
    for (int i = 0; i < n; i++) begin
      send_alu(16'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #0;
    end
  endtask

  task automatic rand_rf(input int n);
    for (int i = 0; i < n; i++) begin
      send_rf(8'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #0;
    end
  endtask

  task automatic rand_busy(input int cycles);
    int t = 0;
    while (t < cycles) begin
      int len;
      len = $urandom_range(1, 6);
      bus.i_tx_busy = ($urandom_range(0, 9) < 3);
      repeat (len) @(posedge clk);
      #1;
      t += len;
    end
    bus.i_tx_busy = 1'b0;
  endtask

  int nbad;

  initial begin
    bus.i_alu_valid = 1'b0;
    bus.i_alu_data  = '0;
    bus.i_rf_valid  = 1'b0;
    bus.i_rf_data   = '0;
    bus.i_tx_busy   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_rf(8'hA5);
    settle();
    send_alu(16'h1234);
    settle();

    fork
      begin
        send_alu(16'hBEEF);
        send_alu(16'hBEEF);
      end
      send_rf(8'h5A);
    join
    settle();

    fork
      send_alu(16'hC3D2);
      begin
        wait_en(1'b1);
        wait_en(1'b0);
        @(posedge clk);
        #1 bus.i_tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.i_tx_busy = 1'b0;
      end
    join
    settle();

    bus.i_tx_busy  = 1'b1;
    bus.i_rf_valid = 1'b1;
    bus.i_rf_data  = 8'h3C;
    nbad = 0;
    repeat (8) begin
      @(negedge clk);
      nbad += int'(bus.o_rf_ready | bus.o_tx_en);
    end
    chk("idle_busy_block", nbad, 0);
    @(posedge clk);
    #1 bus.i_tx_busy = 1'b0;
    @(negedge clk);
    chk("grant_not_early", bus.o_rf_ready, 0);
    @(negedge clk);
    chk("grant_first_free", bus.o_rf_ready, 1);
    @(posedge clk);
    #1 bus.i_rf_valid = 1'b0;
    settle();

    send_alu(16'h7788);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", bus.o_tx_en, 0);
    chk("rst_mid_data", bus.o_tx_data, 0);
    @(posedge clk);
    #1;
    send_alu(16'h7788);
    settle();

    fork
      rand_alu(10);
      rand_rf(10);
      rand_busy(500);
    join
    settle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
